uart_mmio_responder: RTL and testbench

//  CPU-side responder for the UART memory-mapped window 0x8000_0000-0x8000_000C. Consumes the

---
 rtl/uart_mmio_responder_pkg.sv | 26 ++
 rtl/uart_mmio_responder_if.sv | 22 ++
 rtl/uart_mmio_responder_fifo.sv | 41 ++++
 rtl/uart_mmio_responder.sv | 146 ++++++++++++++
 tb/tb_uart_mmio_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_mmio_responder_pkg.sv
// Shared definitions for the UART MMIO window: addresses, status bit positions
// and the serializer state encoding.
package uart_mmio_responder_pkg;

  localparam logic [31:0] UART_BASE     = 32'h8000_0000;
  localparam logic [31:0] OFF_RX_STATUS = 32'h0;
  localparam logic [31:0] OFF_TX_STATUS = 32'h4;
  localparam logic [31:0] OFF_TX_DATA   = 32'h8;
  localparam logic [31:0] OFF_RX_DATA   = 32'hC;

  localparam logic [31:0] ADDR_RX_STATUS = UART_BASE + OFF_RX_STATUS;
  localparam logic [31:0] ADDR_TX_STATUS = UART_BASE + OFF_TX_STATUS;
  localparam logic [31:0] ADDR_TX_DATA   = UART_BASE + OFF_TX_DATA;
  localparam logic [31:0] ADDR_RX_DATA   = UART_BASE + OFF_RX_DATA;

  localparam int STAT_READY_BIT = 0;
  localparam int STAT_OVF_BIT   = 1;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/uart_mmio_responder_if.sv
// CPU bus strobes, RX receiver handshake and the TX line, grouped for the responder.
interface uart_mmio_responder_if;
  logic [31:0] Address;
  logic        WEUART;
  logic        REUART;
  logic [7:0]  WriteData;
  logic [31:0] ReadData;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        SerialOut;

  modport master (
    output Address, WEUART, REUART, WriteData, rx_data, rx_valid,
    input  ReadData, rx_ready, SerialOut
  );

  modport slave (
    input  Address, WEUART, REUART, WriteData, rx_data, rx_valid,
    output ReadData, rx_ready, SerialOut
  );
endinterface

// File: rtl/uart_mmio_responder_fifo.sv
// Byte FIFO with extra-MSB pointers; head is visible combinationally so reads
// can return the byte being popped in the same cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        push_ok, pop_ok;

  // Full/empty are pre-edge values: a push on a full FIFO is dropped even if a pop frees a slot.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/uart_mmio_responder.sv
// UART MMIO responder: decodes the CPU window, buffers TX/RX bytes and drives
// an 8N1 serializer from the TX FIFO.
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  uart_mmio_responder_if.slave    bus
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic       tx_ovf_q, rx_ovf_q;

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             bit_end, serial_out;

  assign tx_push = bus.WEUART && (bus.Address == ADDR_TX_DATA);
  assign rx_pop  = bus.REUART && (bus.Address == ADDR_RX_DATA);

  uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n),
    .push_i(tx_push), .din_i(bus.WriteData), .pop_i(tx_pop),
    .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n),
    .push_i(bus.rx_valid), .din_i(bus.rx_data), .pop_i(rx_pop),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign bus.rx_ready  = !rx_full;
  assign bus.SerialOut = serial_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (tx_push && tx_full)      tx_ovf_q <= 1'b1;
      if (bus.rx_valid && rx_full) rx_ovf_q <= 1'b1;
    end
  end

  always_comb begin
    bus.ReadData = '0;
    case (bus.Address)
      ADDR_RX_STATUS: begin
        bus.ReadData[STAT_READY_BIT] = !rx_empty;
        bus.ReadData[STAT_OVF_BIT]   = rx_ovf_q;
      end
      ADDR_TX_STATUS: begin
        bus.ReadData[STAT_READY_BIT] = !tx_full;
        bus.ReadData[STAT_OVF_BIT]   = tx_ovf_q;
      end
      ADDR_RX_DATA: if (!rx_empty) bus.ReadData[7:0] = rx_head;
      default: ;
    endcase
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_pop     = 1'b0;
    serial_out = 1'b1;
    case (state_q)
      SER_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          shift_d = tx_head;
          cnt_d   = '0;
          state_d = SER_START;
        end
      end
      SER_START: begin
        serial_out = 1'b0;
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = SER_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SER_DATA: begin
        serial_out = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = SER_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SER_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave without an idle gap.
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            shift_d = tx_head;
            state_d = SER_START;
          end else begin
            state_d = SER_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SER_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio_responder.sv
// Bench for uart_mmio_responder: directed TX frames, burst overflow, async reset,
// and a randomized RX/decode phase checked against a queue model.
module tb_uart_mmio_responder;
  import uart_mmio_responder_pkg::*;

  localparam int CLOCK_FREQ = 460_800;
  localparam int BAUD_RATE  = 115_200;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
  localparam int DEPTH      = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_mmio_responder_if bus();

  uart_mmio_responder #(
    .CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_model[$];
  logic [7:0] tx_exp[$];
  logic       m_rx_ovf = 1'b0;
  logic       m_tx_ovf = 1'b0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // A frame as seen on the line: start 0, eight data bits LSB first, stop 1, each CPB samples.
  function automatic logic [63:0] frame_bits(input logic [7:0] b);
    logic [63:0] v = '0;
    for (int i = 0; i < 10 * CPB; i++) begin
      int slot = i / CPB;
      if (slot == 0)      v[i] = 1'b0;
      else if (slot == 9) v[i] = 1'b1;
      else                v[i] = b[slot-1];
    end
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] r = '0;
    if (addr == ADDR_RX_STATUS)      r = {30'd0, m_rx_ovf, rx_model.size() != 0};
    else if (addr == ADDR_TX_STATUS) r = {30'd0, m_tx_ovf, 1'b1};
    else if (addr == ADDR_RX_DATA && rx_model.size() != 0) r = {24'd0, rx_model[0]};
    return r;
  endfunction

  task automatic bus_idle();
    bus.Address = '0; bus.WEUART = 1'b0; bus.REUART = 1'b0;
    bus.WriteData = '0; bus.rx_valid = 1'b0; bus.rx_data = '0;
  endtask

  task automatic sample_line(input int n, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[i] = bus.SerialOut;
      @(negedge clk);
    end
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [7:0] data);
    bus.Address = addr; bus.WriteData = data; bus.WEUART = 1'b1; bus.REUART = 1'b0;
    @(negedge clk);
    bus.WEUART = 1'b0;
  endtask

  task automatic cpu_peek(input logic [31:0] addr, output logic [31:0] d);
    bus.Address = addr; bus.WEUART = 1'b0; bus.REUART = 1'b0;
    #1;
    d = bus.ReadData;
  endtask

  // One clock of RX traffic: check combinational outputs, then advance the model past the edge.
  task automatic rx_cycle(input logic valid, input logic [7:0] data, input logic re,
                          input logic we, input logic [31:0] addr);
    logic full;
    bus.rx_valid = valid; bus.rx_data = data; bus.REUART = re; bus.WEUART = we;
    bus.WriteData = 8'($urandom); bus.Address = addr;
    #1;
    expect_eq("rd_data", bus.ReadData, model_read(addr));
    expect_eq("rx_ready", bus.rx_ready, rx_model.size() < DEPTH);
    @(negedge clk);
    full = (rx_model.size() == DEPTH);
    if (re && addr == ADDR_RX_DATA && rx_model.size() != 0) void'(rx_model.pop_front());
    if (valid) begin
      if (full) m_rx_ovf = 1'b1;
      else      rx_model.push_back(data);
    end
    bus_idle();
  endtask

  initial begin
    logic [63:0] v;
    logic [31:0] d;
    logic [7:0]  b;
    int          tx_cnt;
    logic [31:0] addrs [5];
    addrs[0] = ADDR_RX_STATUS; addrs[1] = ADDR_TX_STATUS; addrs[2] = ADDR_TX_DATA;
    addrs[3] = ADDR_RX_DATA;   addrs[4] = UART_BASE + 32'h10;

    bus_idle();
    reset_n = 1'b0;
    #1;
    expect_eq("reset_line", bus.SerialOut, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cpu_peek(ADDR_TX_STATUS, d); expect_eq("rst_tx_stat", d, 32'h1);
    cpu_peek(ADDR_RX_STATUS, d); expect_eq("rst_rx_stat", d, 32'h0);
    cpu_peek(ADDR_RX_DATA, d);   expect_eq("rst_rx_data", d, 32'h0);
    cpu_peek(ADDR_TX_DATA, d);   expect_eq("rst_tx_data", d, 32'h0);
    expect_eq("rst_rx_ready", bus.rx_ready, 1'b1);
    @(negedge clk);

    // Single frames: 0xA5 then a random byte.
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      cpu_write(ADDR_TX_DATA, b);
      @(negedge clk);
      sample_line(10 * CPB, v); expect_eq("tx_frame", v, frame_bits(b));
      sample_line(4, v);        expect_eq("tx_idle", v, 64'hF);
    end

    // Burst while busy: four bytes fit, the fifth is dropped and frames chain without gaps.
    tx_exp.delete();
    tx_exp.push_back(8'h5A);
    cpu_write(ADDR_TX_DATA, 8'h5A);
    tx_cnt = 0;
    fork
      begin
        int idx = 0;
        logic [63:0] fv;
        @(negedge clk);
        while (idx < tx_exp.size()) begin
          sample_line(10 * CPB, fv); expect_eq("burst_frame", fv, frame_bits(tx_exp[idx]));
          idx++;
        end
        sample_line(8, fv); expect_eq("burst_idle", fv, 64'hFF);
      end
      begin
        logic [31:0] sd;
        @(negedge clk); @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
          cpu_peek(ADDR_TX_STATUS, sd);
          expect_eq("burst_stat", sd, {30'd0, m_tx_ovf, tx_cnt < DEPTH});
          cpu_write(ADDR_TX_DATA, 8'(k));
          if (tx_cnt < DEPTH) begin tx_exp.push_back(8'(k)); tx_cnt++; end
          else m_tx_ovf = 1'b1;
        end
        cpu_peek(ADDR_TX_STATUS, sd);
        expect_eq("burst_ovf", sd, {30'd0, m_tx_ovf, tx_cnt < DEPTH});
        bus_idle();
      end
    join
    cpu_peek(ADDR_TX_STATUS, d); expect_eq("drained_stat", d, 32'h3);
    @(negedge clk);

    // Asynchronous reset in the middle of a frame.
    cpu_write(ADDR_TX_DATA, 8'($urandom));
    @(negedge clk);
    expect_eq("mid_start", bus.SerialOut, 1'b0);
    repeat ($urandom_range(0, 30)) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 expect_eq("mid_abort", bus.SerialOut, 1'b1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    m_tx_ovf = 1'b0;
    cpu_peek(ADDR_TX_STATUS, d); expect_eq("post_tx_stat", d, 32'h1);
    cpu_peek(ADDR_RX_STATUS, d); expect_eq("post_rx_stat", d, 32'h0);
    @(negedge clk);
    sample_line(44, v); expect_eq("post_idle", v, 64'hFFF_FFFF_FFFF);

    // RX directed: two bytes, pop three times, status back to empty.
    rx_cycle(1'b1, 8'h3C, 1'b0, 1'b0, ADDR_RX_STATUS);
    rx_cycle(1'b1, 8'h7E, 1'b0, 1'b0, ADDR_RX_STATUS);
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, ADDR_RX_STATUS);
    repeat (3) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, ADDR_RX_DATA);
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, ADDR_RX_STATUS);

    // RX full: five pushes, drain to two, then same-edge push and pop.
    repeat (5) rx_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, ADDR_RX_STATUS);
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, ADDR_RX_STATUS);
    repeat (2) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, ADDR_RX_DATA);
    rx_cycle(1'b1, 8'($urandom), 1'b1, 1'b0, ADDR_RX_DATA);
    repeat (3) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, ADDR_RX_DATA);

    // Decode: write strobe on the RX data address, read strobe on the TX data address.
    rx_cycle(1'b1, 8'h11, 1'b0, 1'b0, ADDR_RX_STATUS);
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b1, ADDR_RX_DATA);
    rx_cycle(1'b0, 8'h00, 1'b1, 1'b0, ADDR_TX_DATA);
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, ADDR_RX_DATA);
    cpu_peek(ADDR_TX_STATUS, d); expect_eq("decode_tx_stat", d, 32'h1);
    @(negedge clk);
    sample_line(8, v); expect_eq("decode_idle", v, 64'hFF);

    // Randomized RX traffic with mixed addresses and stray write strobes.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a = addrs[$urandom_range(0, 4)];
      logic        we = (a != ADDR_TX_DATA) && ($urandom_range(0, 3) == 0);
      rx_cycle(1'($urandom), 8'($urandom), 1'($urandom), we, a);
    end
    cpu_peek(ADDR_TX_STATUS, d); expect_eq("rand_tx_stat", d, 32'h1);
    expect_eq("rand_line", bus.SerialOut, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
